// File: rtl/adder_rv_fifo.sv
// rtl/adder_rv_fifo.sv - ready/valid add/subtract unit with a DEPTH-entry result queue
//
// The result is computed when a pair is accepted and stored with its
// carry/borrow flag in a circular buffer. in_ready is a function of the
// occupancy counter and flush only. It never depends on out_ready, so the
// consumer side cannot stall the producer side combinationally.
//
// Optional build macro ADDER_RV_FIFO_SAT_EN selects saturating results:
//   add with carry -> all ones, sub with borrow -> zero.
// out_carry always reports the raw carry or borrow.

module adder_rv_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_a,
   input  logic [W-1:0]               in_b,
   input  logic                       in_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [W-1:0]               out_sum,
   output logic                       out_carry,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int LW = $clog2(DEPTH + 1);
   // A single-entry queue still needs a 1-bit pointer so the array index is legal.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);

   logic [W-1:0]  r_mem_sum   [DEPTH];
   logic          r_mem_carry [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [LW-1:0] r_level;

   logic          w_push;
   logic          w_pop;
   logic [W:0]    w_add_full;
   logic [W:0]    w_sub_full;
   logic [W:0]    w_res_full;
   logic          w_res_carry;
   logic [W-1:0]  w_res_sum_raw;
   logic [W-1:0]  w_res_sum;

   // Pointers wrap from DEPTH-1 back to 0, so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == PTR_LAST) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign in_ready  = (r_level != LEVEL_FULL) && !flush;
   assign out_valid = (r_level != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Both operations are done at W+1 bits: bit W is the carry for an add and
   // the borrow (A < B) for a subtract, because the zero-extended difference
   // goes negative exactly when A < B.
   assign w_add_full    = {1'b0, in_a} + {1'b0, in_b};
   assign w_sub_full    = {1'b0, in_a} - {1'b0, in_b};
   assign w_res_full    = in_op ? w_sub_full : w_add_full;
   assign w_res_carry   = w_res_full[W];
   assign w_res_sum_raw = w_res_full[W-1:0];

`ifdef ADDER_RV_FIFO_SAT_EN
   // Clamp to the range limit in the direction of the overflow.
   always_comb begin
      w_res_sum = w_res_sum_raw;
      if (w_res_carry) begin
         w_res_sum = in_op ? '0 : '1;
      end
   end
`else
   assign w_res_sum = w_res_sum_raw;
`endif

   // Result storage: written once at push and never recomputed; cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_sum[i]   <= '0;
            r_mem_carry[i] <= 1'b0;
         end
      end else if (w_push) begin
         r_mem_sum[r_wptr]   <= w_res_sum;
         r_mem_carry[r_wptr] <= w_res_carry;
      end
   end

   // Write pointer advances on push; flush returns it to the first slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
      end else if (flush) begin
         r_wptr <= '0;
      end else if (w_push) begin
         r_wptr <= ptr_next(r_wptr);
      end
   end

   // Read pointer advances on pop; a pop during flush is honoured but the entry is dropped with the rest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr <= '0;
      end else if (flush) begin
         r_rptr <= '0;
      end else if (w_pop) begin
         r_rptr <= ptr_next(r_rptr);
      end
   end

   // Occupancy counter; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level <= '0;
      end else if (flush) begin
         r_level <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign out_sum   = r_mem_sum[r_rptr];
   assign out_carry = r_mem_carry[r_rptr];
   assign level     = r_level;

endmodule

// File: tb/tb_adder_rv_fifo.sv
// tb/tb_adder_rv_fifo.sv - scoreboard bench for adder_rv_fifo (W=8, DEPTH=4)

module tb_adder_rv_fifo;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_carry;
   logic [2:0] level;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_out  = 0;

   logic [8:0] sb[$];

   adder_rv_fifo #(.W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .level     (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every completed pop is compared with the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         n_out++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got carry=%0d sum=%0d expected none", out_carry, out_sum);
         end else begin
            logic [8:0] e;
            e = sb.pop_front();
            if ({out_carry, out_sum} !== e) begin
               n_fail++;
               $display("FAIL result: got carry=%0d sum=%0d expected carry=%0d sum=%0d",
                        out_carry, out_sum, e[8], e[7:0]);
            end
         end
      end
   end

   // Called at posedge+1; presents one pair for one cycle and records it if accepted.
   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic op,
                        input logic [8:0] exp, output bit acc, output int lvl);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      @(negedge clk);
      acc = in_ready;
      lvl = int'(level);
      if (acc) sb.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for the queue and the scoreboard to empty; ends at posedge+1.
   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) done = 1'b1;
      end
      check({name, "_drain_done"}, int'(done), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit acc;
      int lvl;
      int naccept;
      int out_before;

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum",   int'(out_sum),   0);
      check("rst_out_carry", int'(out_carry), 0);
      check("rst_level",     int'(level),     0);
      @(posedge clk);
      #1;

      // Single add 5+7, consumer ready
      drive(8'd5, 8'd7, 1'b0, {1'b0, 8'd12}, acc, lvl);
      check("add57_accept", int'(acc), 1);
      @(negedge clk);
      check("add57_out_valid", int'(out_valid), 1);
      check("add57_level1",    int'(level),     1);
      @(negedge clk);
      check("add57_level0",    int'(level),     0);
      check("add57_empty",     int'(out_valid), 0);
      @(posedge clk);
      #1;

      // Carry / borrow vectors
`ifdef ADDER_RV_FIFO_SAT_EN
      drive(8'd200, 8'd100, 1'b0, {1'b1, 8'd255}, acc, lvl);
      drive(8'd3,   8'd5,   1'b1, {1'b1, 8'd0},   acc, lvl);
`else
      drive(8'd200, 8'd100, 1'b0, {1'b1, 8'd44},  acc, lvl);
      drive(8'd3,   8'd5,   1'b1, {1'b1, 8'd254}, acc, lvl);
`endif
      drive(8'd9,   8'd4,   1'b1, {1'b0, 8'd5},   acc, lvl);
      drive(8'd255, 8'd255, 1'b1, {1'b0, 8'd0},   acc, lvl);
      wait_drain("arith");

      // Fill with consumer stalled: 6 offered, 4 accepted
      out_ready = 1'b0;
      naccept   = 0;
      for (int i = 1; i <= 6; i++) begin
         drive(8'(i), 8'd0, 1'b0, {1'b0, 8'(i)}, acc, lvl);
         if (acc) naccept++;
      end
      @(negedge clk);
      check("fill_accepted", naccept,         4);
      check("fill_level",    int'(level),     4);
      check("fill_in_ready", int'(in_ready),  0);
      check("fill_hold_sum", int'(out_sum),   1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("fill_ready_before_pop", int'(in_ready), 0);
      @(negedge clk);
      check("fill_ready_after_pop",  int'(in_ready), 1);
      check("fill_level_after_pop",  int'(level),    3);
      @(posedge clk);
      #1;
      wait_drain("fill");

      // Streaming: 20 back-to-back transactions, consumer always ready
      out_before = n_out;
      for (int i = 0; i < 20; i++) begin
         drive(8'(10 * i), 8'(i), 1'b0, {1'b0, 8'(11 * i)}, acc, lvl);
         check("stream_accept", int'(acc), 1);
         check("stream_level",  lvl, (i == 0) ? 0 : 1);
      end
      wait_drain("stream");
      check("stream_count", n_out - out_before, 20);

      // Flush at level 3 with a pair offered
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(8'(i), 8'd0, 1'b0, {1'b0, 8'(i)}, acc, lvl);
      end
      @(negedge clk);
      check("flush_pre_level", int'(level), 3);
      @(posedge clk);
      #1;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_a     = 8'd50;
      in_b     = 8'd0;
      in_op    = 1'b0;
      @(negedge clk);
      check("flush_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      check("flush_level",     int'(level),     0);
      check("flush_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drive(8'd7, 8'd1, 1'b0, {1'b0, 8'd8}, acc, lvl);
      wait_drain("flush");

      // Asynchronous reset with two entries queued
      out_ready = 1'b0;
      drive(8'd1, 8'd1, 1'b0, {1'b0, 8'd2}, acc, lvl);
      drive(8'd2, 8'd3, 1'b0, {1'b0, 8'd5}, acc, lvl);
      @(negedge clk);
      check("arst_pre_level", int'(level), 2);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_level",     int'(level),     0);
      check("arst_in_ready",  int'(in_ready),  1);
      check("arst_out_sum",   int'(out_sum),   0);
      check("arst_out_carry", int'(out_carry), 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      drive(8'd2, 8'd2, 1'b0, {1'b0, 8'd4}, acc, lvl);
      check("arst_push_accept", int'(acc), 1);
      wait_drain("arst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
